mem_byte_sequencer: RTL

//  Sits between the EX/MEM pipeline register and the byte-wide data memory (8-bit x 2**ADDR_W).

---
 rtl/mem_byte_sequencer_if.sv | 33 +++
 rtl/mem_byte_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer_if.sv
// Bus bundle between the EX/MEM stage, the byte sequencer and the byte-wide data memory.
// The slave modport is the sequencer's view; master is the pipeline/memory side.
interface mem_byte_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              memRead_i;
    logic              memWrite_i;
    logic [1:0]        size_i;
    logic              signed_i;
    logic [31:0]       addr_i;
    logic [31:0]       wdata_i;
    logic              stall_o;
    logic              done_o;
    logic              misalign_o;
    logic [31:0]       rdata_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic [7:0]        mem_rdata_i;

    modport slave (
        input  memRead_i, memWrite_i, size_i, signed_i, addr_i, wdata_i, mem_rdata_i,
        output stall_o, done_o, misalign_o, rdata_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output memRead_i, memWrite_i, size_i, signed_i, addr_i, wdata_i, mem_rdata_i,
        input  stall_o, done_o, misalign_o, rdata_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Splits one byte/half/word load or store into 1, 2 or 4 little-endian byte beats,
// stalling the pipeline while beats run and assembling/extending load data.
module mem_byte_sequencer #(
    parameter int ADDR_W = 5
) (
    input logic                 clk_i,
    input logic                 rst_i,
    mem_byte_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rdata_q;
    logic [1:0]        size_q;
    logic [1:0]        beat_q;
    logic [1:0]        last_beat;
    logic              signed_q;
    logic              store_q;
    logic              req;
    logic              misaligned;
    logic              accept;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic sgn);
        case (sz)
            2'b00:   extend = {{24{sgn & v[7]}}, v[7:0]};
            2'b01:   extend = {{16{sgn & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign req        = bus.memRead_i | bus.memWrite_i;
    assign misaligned = ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                        (bus.size_i[1] && (bus.addr_i[1:0] != 2'b00));
    assign last_beat  = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;

    always_comb begin
        asm_d = asm_q;
        asm_d[{beat_q, 3'b000} +: 8] = bus.mem_rdata_i;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d         = state_q;
        accept          = 1'b0;
        bus.stall_o     = 1'b0;
        bus.done_o      = 1'b0;
        bus.misalign_o  = 1'b0;
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                // Reset holds state in IDLE, so gating here keeps every output low during reset.
                if (rst_i && req) begin
                    if (misaligned) begin
                        bus.misalign_o = 1'b1;
                    end else begin
                        bus.stall_o = 1'b1;
                        accept      = 1'b1;
                        state_d     = XFER;
                    end
                end
            end
            XFER: begin
                bus.stall_o    = 1'b1;
                bus.mem_addr_o = base_q + ADDR_W'(beat_q);
                if (store_q) begin
                    bus.mem_write_o = 1'b1;
                    bus.mem_wdata_o = wdata_q[{beat_q, 3'b000} +: 8];
                end else begin
                    bus.mem_read_o = 1'b1;
                end
                if (beat_q == last_beat) state_d = DONE;
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            base_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            beat_q   <= '0;
            signed_q <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (accept) begin
                base_q   <= bus.addr_i[ADDR_W-1:0];
                wdata_q  <= bus.wdata_i;
                size_q   <= bus.size_i;
                signed_q <= bus.signed_i;
                store_q  <= bus.memWrite_i;
                beat_q   <= '0;
                asm_q    <= '0;
            end else if (state_q == XFER) begin
                beat_q <= beat_q + 2'd1;
                if (!store_q) begin
                    asm_q <= asm_d;
                    if (beat_q == last_beat) rdata_q <= extend(asm_d, size_q, signed_q);
                end
            end
        end
    end

    assign bus.rdata_o = rdata_q;
endmodule
